// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Fetch stage of the pipelined LC-3b datapath. Owns the PC register and the
// instruction-memory read handshake, and fills the IF/ID register. Taken
// branches, JSR, TRAP and JMP redirect the PC through the 2-bit PC select.
// Wrong-path fetches are squashed, and a one-entry skid buffer catches a
// response that arrives while decode is stalled.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high
//   redirect_valid in   control instruction resolved this cycle
//   pc_sel         in   00 seq, 01 br_target, 10 trap_vector, 11 jmp_target
//   br_target      in   branch / JSR target
//   trap_vector    in   TRAP target
//   jmp_target     in   JMP / RET target
//   stall          in   decode cannot accept; IF/ID holds
//   imem_read      out  instruction-memory read request
//   imem_addr      out  request address
//   imem_resp      in   one-cycle response strobe
//   imem_rdata     in   instruction word, valid with imem_resp
//   if_valid       out  IF/ID holds a valid instruction
//   if_pc          out  address of the IF/ID instruction
//   if_pc_plus2    out  if_pc + 2 (mod 2^16), registered with if_pc
//   if_ir          out  IF/ID instruction word
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] br_target,
    input  logic [15:0] trap_vector,
    input  logic [15:0] jmp_target,
    input  logic        stall,
    output logic        imem_read,
    output logic [15:0] imem_addr,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic [15:0] if_ir
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding, response goes to IF/ID
        DRAIN = 2'd1,   // request outstanding, response is wrong-path
        HOLD  = 2'd2    // skid buffer full, no request issued
    } state_t;

    state_t      state, state_next;

    logic [15:0] pc, pc_next;
    logic [15:0] req_addr, req_addr_next;
    logic [15:0] hold_ir, hold_ir_next;
    logic [15:0] hold_pc, hold_pc_next;

    logic        if_valid_next;
    logic [15:0] if_pc_next, if_pc_plus2_next, if_ir_next;

    logic        redirect;
    logic [15:0] target;
    logic        load_en;

    // IF/ID load request from the state logic, resolved against redirect below
    logic        ifid_load;
    logic [15:0] ifid_pc_src, ifid_ir_src;

    assign redirect = redirect_valid && (pc_sel != 2'b00);
    assign load_en  = !if_valid || !stall;

    always_comb begin
        target = br_target;
        case (pc_sel)
            2'b01:   target = br_target;
            2'b10:   target = trap_vector;
            2'b11:   target = jmp_target;
            default: target = br_target;
        endcase
    end

    // The request is held stable until its response; only reset may drop it.
    assign imem_read = !reset && (state != HOLD);
    assign imem_addr = req_addr;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        hold_ir_next  = hold_ir;
        hold_pc_next  = hold_pc;
        ifid_load     = 1'b0;
        ifid_pc_src   = req_addr;
        ifid_ir_src   = imem_rdata;

        case (state)
            FETCH: begin
                if (imem_resp) begin
                    if (redirect) begin
                        // Response is wrong-path; refetch from the target.
                        pc_next       = target;
                        req_addr_next = target;
                    end else if (load_en) begin
                        ifid_load     = 1'b1;
                        ifid_pc_src   = req_addr;
                        ifid_ir_src   = imem_rdata;
                        pc_next       = req_addr + 16'd2;
                        req_addr_next = req_addr + 16'd2;
                    end else begin
                        hold_ir_next  = imem_rdata;
                        hold_pc_next  = req_addr;
                        state_next    = HOLD;
                    end
                end else if (redirect) begin
                    // The in-flight request cannot be aborted; drain it first.
                    pc_next    = target;
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    pc_next = target;
                end
                if (imem_resp) begin
                    req_addr_next = redirect ? target : pc;
                    state_next    = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_next       = target;
                    req_addr_next = target;
                    state_next    = FETCH;
                end else if (load_en) begin
                    ifid_load     = 1'b1;
                    ifid_pc_src   = hold_pc;
                    ifid_ir_src   = hold_ir;
                    pc_next       = hold_pc + 16'd2;
                    req_addr_next = hold_pc + 16'd2;
                    state_next    = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // IF/ID update: redirect squashes, otherwise load a new instruction, or
    // insert a bubble once decode has consumed the current one.
    always_comb begin
        if_valid_next    = if_valid;
        if_pc_next       = if_pc;
        if_pc_plus2_next = if_pc_plus2;
        if_ir_next       = if_ir;
        if (redirect) begin
            if_valid_next = 1'b0;
        end else if (ifid_load) begin
            if_valid_next    = 1'b1;
            if_pc_next       = ifid_pc_src;
            if_pc_plus2_next = ifid_pc_src + 16'd2;
            if_ir_next       = ifid_ir_src;
        end else if (load_en) begin
            if_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            hold_ir     <= 16'h0000;
            hold_pc     <= 16'h0000;
            if_valid    <= 1'b0;
            if_pc       <= 16'h0000;
            if_pc_plus2 <= 16'h0000;
            if_ir       <= 16'h0000;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            req_addr    <= req_addr_next;
            hold_ir     <= hold_ir_next;
            hold_pc     <= hold_pc_next;
            if_valid    <= if_valid_next;
            if_pc       <= if_pc_next;
            if_pc_plus2 <= if_pc_plus2_next;
            if_ir       <= if_ir_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Instance u_dut uses RESET_PC = 0000 and a
// memory with programmable latency; instance u_wrap uses RESET_PC = FFFE with
// a 1-cycle memory and never redirects or stalls. Memory returns ~addr.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] trap_vector = 16'h0000;
    logic [15:0] jmp_target = 16'h0000;
    logic        stall = 1'b0;

    logic        imem_read, imem_resp, if_valid;
    logic [15:0] imem_addr, imem_rdata, if_pc, if_pc_plus2, if_ir;

    logic        w_imem_read, w_imem_resp, w_if_valid;
    logic [15:0] w_imem_addr, w_imem_rdata, w_if_pc, w_if_pc_plus2, w_if_ir;

    int mem_lat = 1;
    int cnt = 0;
    int w_cnt = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) u_dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .pc_sel(pc_sel),
        .br_target(br_target), .trap_vector(trap_vector), .jmp_target(jmp_target),
        .stall(stall), .imem_read(imem_read), .imem_addr(imem_addr),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_pc_plus2(if_pc_plus2), .if_ir(if_ir)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .reset(reset), .redirect_valid(1'b0), .pc_sel(2'b00),
        .br_target(16'h0000), .trap_vector(16'h0000), .jmp_target(16'h0000),
        .stall(1'b0), .imem_read(w_imem_read), .imem_addr(w_imem_addr),
        .imem_resp(w_imem_resp), .imem_rdata(w_imem_rdata), .if_valid(w_if_valid),
        .if_pc(w_if_pc), .if_pc_plus2(w_if_pc_plus2), .if_ir(w_if_ir)
    );

    // Memory models: response after mem_lat cycles of an asserted read.
    assign imem_resp    = imem_read && (cnt == mem_lat - 1);
    assign imem_rdata   = ~imem_addr;
    assign w_imem_resp  = w_imem_read;
    assign w_imem_rdata = ~w_imem_addr;

    always @(posedge clk) begin
        if (imem_read && !imem_resp) cnt <= cnt + 1;
        else cnt <= 0;
    end

    always @(posedge clk) begin
        if (w_imem_read && !w_imem_resp) w_cnt <= w_cnt + 1;
        else w_cnt <= 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++; if (imem_read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b expected 0", imem_read); end
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        tests++; if ({if_pc, if_pc_plus2, if_ir} !== 48'h0) begin fails++; $display("FAIL reset_ifid: got %h expected 0", {if_pc, if_pc_plus2, if_ir}); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
        tests++; if (w_imem_addr !== 16'hFFFE) begin fails++; $display("FAIL reset_addr_wrap: got %h expected fffe", w_imem_addr); end
        reset = 1'b0;
        #1;
        tests++; if (imem_read !== 1'b1 || imem_addr !== 16'h0000) begin fails++; $display("FAIL first_req: got read=%b addr=%h expected 1/0000", imem_read, imem_addr); end
    endtask

    task automatic test_sequential();
        step();
        tests++; if (imem_addr !== 16'h0002) begin fails++; $display("FAIL seq_addr1: got %h expected 0002", imem_addr); end
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_pc_plus2 !== 16'h0002 || if_ir !== 16'hFFFF) begin
            fails++; $display("FAIL seq_ifid0: got v=%b pc=%h p2=%h ir=%h expected 1/0000/0002/ffff", if_valid, if_pc, if_pc_plus2, if_ir); end
        step();
        tests++; if (imem_addr !== 16'h0004) begin fails++; $display("FAIL seq_addr2: got %h expected 0004", imem_addr); end
        tests++; if (if_pc !== 16'h0002 || if_pc_plus2 !== 16'h0004 || if_ir !== 16'hFFFD) begin
            fails++; $display("FAIL seq_ifid2: got pc=%h p2=%h ir=%h expected 0002/0004/fffd", if_pc, if_pc_plus2, if_ir); end
    endtask

    task automatic test_stall_skid();
        // Response for 0004 arrives this cycle while decode stalls.
        stall = 1'b1;
        step();
        tests++; if (imem_read !== 1'b0) begin fails++; $display("FAIL skid_read: got %b expected 0", imem_read); end
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h0002 || if_ir !== 16'hFFFD) begin
            fails++; $display("FAIL skid_hold1: got v=%b pc=%h ir=%h expected 1/0002/fffd", if_valid, if_pc, if_ir); end
        step();
        tests++; if (imem_read !== 1'b0 || if_pc !== 16'h0002 || if_ir !== 16'hFFFD) begin
            fails++; $display("FAIL skid_hold2: got read=%b pc=%h ir=%h expected 0/0002/fffd", imem_read, if_pc, if_ir); end
        stall = 1'b0;
        step();
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h0004 || if_pc_plus2 !== 16'h0006 || if_ir !== 16'hFFFB) begin
            fails++; $display("FAIL skid_release: got v=%b pc=%h p2=%h ir=%h expected 1/0004/0006/fffb", if_valid, if_pc, if_pc_plus2, if_ir); end
        tests++; if (imem_read !== 1'b1 || imem_addr !== 16'h0006) begin fails++; $display("FAIL skid_next_addr: got read=%b addr=%h expected 1/0006", imem_read, imem_addr); end
        step();
        tests++; if (if_pc !== 16'h0006 || imem_addr !== 16'h0008) begin fails++; $display("FAIL skid_after: got pc=%h addr=%h expected 0006/0008", if_pc, imem_addr); end
    endtask

    task automatic test_not_taken();
        redirect_valid = 1'b1;
        pc_sel         = 2'b00;
        br_target      = 16'h1234;
        trap_vector    = 16'h0400;
        jmp_target     = 16'h3000;
        step();
        redirect_valid = 1'b0;
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h0008 || imem_addr !== 16'h000A) begin
            fails++; $display("FAIL not_taken: got v=%b pc=%h addr=%h expected 1/0008/000a", if_valid, if_pc, imem_addr); end
    endtask

    task automatic test_hold_redirect();
        stall = 1'b1;
        step();
        tests++; if (imem_read !== 1'b0) begin fails++; $display("FAIL hold_enter: got read=%b expected 0", imem_read); end
        redirect_valid = 1'b1;
        pc_sel         = 2'b01;
        br_target      = 16'h1234;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL hold_redir_valid: got %b expected 0", if_valid); end
        tests++; if (imem_read !== 1'b1 || imem_addr !== 16'h1234) begin fails++; $display("FAIL hold_redir_addr: got read=%b addr=%h expected 1/1234", imem_read, imem_addr); end
        step();
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h1234 || if_ir !== 16'hEDCB || imem_addr !== 16'h1236) begin
            fails++; $display("FAIL hold_redir_fetch: got v=%b pc=%h ir=%h addr=%h expected 1/1234/edcb/1236", if_valid, if_pc, if_ir, imem_addr); end
    endtask

    task automatic test_redirect_on_resp();
        redirect_valid = 1'b1;
        pc_sel         = 2'b10;
        trap_vector    = 16'h0400;
        step();
        redirect_valid = 1'b0;
        tests++; if (if_valid !== 1'b0 || imem_addr !== 16'h0400) begin
            fails++; $display("FAIL trap_resp: got v=%b addr=%h expected 0/0400", if_valid, imem_addr); end
        step();
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h0400 || if_ir !== 16'hFBFF) begin
            fails++; $display("FAIL trap_fetch: got v=%b pc=%h ir=%h expected 1/0400/fbff", if_valid, if_pc, if_ir); end
    endtask

    task automatic test_redirect_pending();
        // Request for 0402 has just been issued; switch to a 3-cycle memory.
        mem_lat        = 3;
        redirect_valid = 1'b1;
        pc_sel         = 2'b11;
        jmp_target     = 16'h3000;
        step();
        redirect_valid = 1'b0;
        tests++; if (if_valid !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 16'h0402) begin
            fails++; $display("FAIL jmp_pending1: got v=%b read=%b addr=%h expected 0/1/0402", if_valid, imem_read, imem_addr); end
        step();
        tests++; if (imem_resp !== 1'b1 || imem_addr !== 16'h0402 || if_valid !== 1'b0) begin
            fails++; $display("FAIL jmp_pending2: got resp=%b addr=%h v=%b expected 1/0402/0", imem_resp, imem_addr, if_valid); end
        step();
        tests++; if (imem_addr !== 16'h3000 || if_valid !== 1'b0) begin
            fails++; $display("FAIL jmp_next_req: got addr=%h v=%b expected 3000/0", imem_addr, if_valid); end
        step();
        step();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL jmp_wait: got v=%b expected 0", if_valid); end
        step();
        tests++; if (if_valid !== 1'b1 || if_pc !== 16'h3000 || if_ir !== 16'hCFFF) begin
            fails++; $display("FAIL jmp_fetch: got v=%b pc=%h ir=%h expected 1/3000/cfff", if_valid, if_pc, if_ir); end
    endtask

    task automatic test_drain_latest();
        // Request for 3002 just issued; two redirects during the drain.
        redirect_valid = 1'b1;
        pc_sel         = 2'b11;
        jmp_target     = 16'h5000;
        step();
        pc_sel         = 2'b01;
        br_target      = 16'h6000;
        step();
        redirect_valid = 1'b0;
        tests++; if (imem_addr !== 16'h3002 || imem_resp !== 1'b1) begin
            fails++; $display("FAIL drain_hold_addr: got addr=%h resp=%b expected 3002/1", imem_addr, imem_resp); end
        step();
        tests++; if (imem_addr !== 16'h6000 || if_valid !== 1'b0) begin
            fails++; $display("FAIL drain_latest: got addr=%h v=%b expected 6000/0", imem_addr, if_valid); end
    endtask

    task automatic test_reset_mid_request();
        step();
        reset = 1'b1;
        step();
        tests++; if (imem_read !== 1'b0 || w_imem_read !== 1'b0) begin
            fails++; $display("FAIL rst_mid_read: got %b/%b expected 0/0", imem_read, w_imem_read); end
        tests++; if (if_valid !== 1'b0 || w_if_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_valid: got %b/%b expected 0/0", if_valid, w_if_valid); end
        step();
        tests++; if (imem_read !== 1'b0 || imem_addr !== 16'h0000 || w_imem_addr !== 16'hFFFE) begin
            fails++; $display("FAIL rst_mid_addr: got read=%b addr=%h waddr=%h expected 0/0000/fffe", imem_read, imem_addr, w_imem_addr); end
        reset = 1'b0;
        #1;
        tests++; if (imem_read !== 1'b1 || imem_addr !== 16'h0000 || w_imem_read !== 1'b1 || w_imem_addr !== 16'hFFFE) begin
            fails++; $display("FAIL rst_restart: got %b/%h %b/%h expected 1/0000 1/fffe", imem_read, imem_addr, w_imem_read, w_imem_addr); end
    endtask

    task automatic test_wrap();
        step();
        tests++; if (w_imem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_addr: got %h expected 0000", w_imem_addr); end
        tests++; if (w_if_valid !== 1'b1 || w_if_pc !== 16'hFFFE || w_if_pc_plus2 !== 16'h0000 || w_if_ir !== 16'h0001) begin
            fails++; $display("FAIL wrap_ifid: got v=%b pc=%h p2=%h ir=%h expected 1/fffe/0000/0001", w_if_valid, w_if_pc, w_if_pc_plus2, w_if_ir); end
        step();
        tests++; if (w_if_pc !== 16'h0000 || w_if_pc_plus2 !== 16'h0002 || w_imem_addr !== 16'h0002) begin
            fails++; $display("FAIL wrap_next: got pc=%h p2=%h addr=%h expected 0000/0002/0002", w_if_pc, w_if_pc_plus2, w_imem_addr); end
        tests++; if (imem_addr !== 16'h0000 || if_valid !== 1'b0) begin
            fails++; $display("FAIL wrap_main_wait: got addr=%h v=%b expected 0000/0", imem_addr, if_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_skid();
        test_not_taken();
        test_hold_redirect();
        test_redirect_on_resp();
        test_redirect_pending();
        test_drain_latest();
        test_reset_mid_request();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
